seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 8-digit common-anode 7-segment display.
- Holds one 4-bit hex value and one decimal-point flag per digit, written through a simple write port.
- Cycles the digit select so that all 8 digits appear lit at the same time.
- Inserts a dead-time blank at the start of every digit slot to suppress ghosting.
- Drives SEG/AN (active-low) directly to the board pins, replacing static single-digit drive from switches.

Parameters:
DIV, 100000, clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 2..2^CNT_W.
BLANK, 1000, cycles at the start of each slot with all anodes off; must satisfy 0 <= BLANK < DIV.
CNT_W, 17, width of the slot prescaler counter; must hold DIV-1.

Ports:
CLK  in  1  system clock; all state changes on the rising edge.
RST_N  in  1  asynchronous, active-low reset.
ENABLE  in  1  1 = scan runs; 0 = counters freeze and the display blanks.
EN_MASK  in  8  per-digit enable; bit i = 0 keeps digit i dark, but its slot is still consumed.
WR_EN  in  1  write strobe, one digit per cycle.
WR_ADDR  in  3  digit index to write (0 = rightmost, AN[0]).
WR_DATA  in  4  hex value for that digit.
WR_DP  in  1  decimal point for that digit, 1 = lit.
SEG  out  8  segments, active-low; SEG[7] = DP, SEG[6:0] = g..a.
AN  out  8  digit selects, active-low, at most one bit low.
SCAN_IDX  out  3  digit index of the current slot.
FRAME_TICK  out  1  one-cycle pulse when SCAN_IDX wraps from 7 to 0.

Behaviour:
- Reset (async assert, RST_N low):
  - cnt=0, idx=0.
  - All digit regs = 0, all dp regs = 0.
  - AN=8'hFF, SEG=8'hFF, SCAN_IDX=0, FRAME_TICK=0.
  - A reset mid-slot aborts the slot; the scan restarts at digit 0 with cnt=0.
- Prescaler, at each edge with ENABLE=1:
  - If cnt==DIV-1: cnt<=0 and idx<=idx+1 (mod 8). Otherwise cnt<=cnt+1.
  - SCAN_IDX = idx.
  - FRAME_TICK<=1 on the same edge that idx goes 7->0; 0 on every other edge.
- Output registers (one-cycle latency): computed from the pre-edge cnt, idx, digit regs and dp regs.
  - If ENABLE=0, or cnt<BLANK, or EN_MASK[idx]=0: AN<=FF and SEG<=FF.
  - Otherwise: AN<=~(8'b1<<idx), SEG[6:0]<=hex(digit[idx]), SEG[7]<=~dp[idx].
- Hex encoding of SEG[6:0] (shown with DP off):
  0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=98, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- AN is never driven with more than one low bit, including on digit transitions and when BLANK=0.
- ENABLE=0:
  - cnt, idx hold their values and FRAME_TICK=0.
  - AN/SEG go to FF on the next edge.
  - On re-enable, scanning resumes from the held cnt/idx.
- Writes:
  - With WR_EN=1, digit[WR_ADDR]<=WR_DATA and dp[WR_ADDR]<=WR_DP on the edge.
  - If the written digit is the one currently displayed, SEG shows the old value on that same edge and the new value from the next edge.
  - Writes are accepted while ENABLE=0 and during reset release.
- Slot timing (ENABLE=1, no stalls): each slot is exactly DIV cycles, blanked for BLANK cycles; frame period = 8*DIV cycles.
- EN_MASK is sampled live each cycle; changing it mid-slot takes effect on the next edge.

Test Plan:
1. DIV=8, BLANK=2, EN_MASK=FF, reset released, all digits 0.
   -> Edges 1-2: AN=FF. Edges 3-8: AN=FE, SEG=C0. Edge 9: AN=FF. Edges 11-16: AN=FD.
   -> FRAME_TICK high for exactly one cycle, at edge 64, repeating every 64 cycles.
2. Write digits 0..7 = 1,2,3,4,5,6,7,8, with dp only on digit 3.
   -> Across one frame, the lit phases show SEG = F9, A4, B0, 19, 92, 82, F8, 80 with AN = FE, FD, FB, F7, EF, DF, BF, 7F.
3. EN_MASK=8'b0000_0101.
   -> Only AN=FE and AN=FB ever appear; slots 1 and 3-7 stay FF for their full 8 cycles; frame period stays 64.
4. Drop ENABLE for 20 cycles mid-slot (idx=2, cnt=5).
   -> AN/SEG=FF from the next edge; SCAN_IDX stays 2; after re-enable, 3 more cycles complete slot 2.
5. Write digit 2 = E at the edge where idx=2, cnt=4.
   -> SEG shows the old value at that edge and 86 from the next edge.
   -> Assert RST_N=0 asynchronously at idx=5: AN=FF, SEG=FF, SCAN_IDX=0 immediately, all digit regs read back 0 (SEG=C0 in the next lit phase).
6. BLANK=0.
   -> No blank cycles; AN steps FE->FD at the slot boundary with exactly one low bit on every cycle.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Bundles the digit write port and the display pin outputs of the 7-segment scan controller.
// Pure wiring: no latency of its own.
// No backpressure: writes are always accepted, and the outputs are free-running pin drives.
interface seg7_scan_ctrl_if;
    logic       enable;
    logic [7:0] en_mask;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic [7:0] seg;
    logic [7:0] an;
    logic [2:0] scan_idx;
    logic       frame_tick;

    // Driver side: owns enable/mask/write port and observes the pins.
    modport master (
        output enable, en_mask, wr_en, wr_addr, wr_data, wr_dp,
        input  seg, an, scan_idx, frame_tick
    );

    // Controller side.
    modport slave (
        input  enable, en_mask, wr_en, wr_addr, wr_data, wr_dp,
        output seg, an, scan_idx, frame_tick
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of an 8-digit common-anode display, with dead-time blanking at each slot start.
// Latency: SEG/AN are registered one cycle after the cnt/idx/digit state they reflect.
// No backpressure: one digit write per cycle is always accepted, and ENABLE=0 freezes the scan and blanks the pins.
module seg7_scan_ctrl #(
    parameter int DIV   = 100000,
    parameter int BLANK = 1000,
    parameter int CNT_W = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    seg7_scan_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] LP_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] LP_BLANK = CNT_W'(BLANK);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             r_tick;
    logic [3:0]       r_dig [8];
    logic [7:0]       r_dp;
    logic [7:0]       r_an;
    logic [7:0]       r_seg;

    logic             w_last;
    logic             w_in_blank;
    logic             w_lit;
    logic [3:0]       w_cur_dig;
    logic [6:0]       w_hex;
    logic [7:0]       w_an_sel;

    assign w_last     = (r_cnt == LP_LAST);
    // With BLANK=0 the compare is never true, so slots are lit from their first cycle.
    assign w_in_blank = (r_cnt < LP_BLANK);
    assign w_lit      = bus.enable && !w_in_blank && bus.en_mask[r_idx];
    assign w_cur_dig  = r_dig[r_idx];
    // The shift yields exactly one low bit, so AN can never select two digits.
    assign w_an_sel   = ~(8'b0000_0001 << r_idx);

    // Hex-to-segment decode, active-low, bit order g..a.
    always_comb begin
        w_hex = 7'h7F;
        case (w_cur_dig)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h18;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
            default: w_hex = 7'h7F;
        endcase
    end

    // Slot prescaler and digit index; both freeze while disabled, and the frame tick marks the 7->0 wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_idx  <= 3'd0;
            r_tick <= 1'b0;
        end else if (bus.enable) begin
            if (w_last) begin
                r_cnt  <= '0;
                r_idx  <= r_idx + 3'd1;
                r_tick <= (r_idx == 3'd7);
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    // Digit and decimal-point storage; the write lands on the edge, so the display picks it up one cycle later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_dig[i] <= 4'h0;
            end
            r_dp <= 8'h00;
        end else if (bus.wr_en) begin
            r_dig[bus.wr_addr] <= bus.wr_data;
            r_dp[bus.wr_addr]  <= bus.wr_dp;
        end
    end

    // Registered pin drive: blank when disabled, during dead time, or when the digit is masked.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end else if (w_lit) begin
            r_an  <= w_an_sel;
            r_seg <= {~r_dp[r_idx], w_hex};
        end else begin
            r_an  <= 8'hFF;
            r_seg <= 8'hFF;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.scan_idx   = r_idx;
    assign bus.frame_tick = r_tick;
endmodule
